// File: rtl/fb_bram_arbiter.sv
// Frame-buffer BRAM arbiter: the scanout reader has strict priority, and a
// valid/ready pixel writer is guaranteed a slot after STARVE_MAX stalled cycles.
module fb_bram_arbiter #(
  parameter int HSIZE      = 640,
  parameter int VSIZE      = 480,
  parameter int AW         = 19,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_miss,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          err_oob,
  output logic [15:0]   miss_cnt,
  output logic          bram_en,
  output logic          bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [DW-1:0] bram_wdata,
  input  logic [DW-1:0] bram_rdata
);

  localparam logic [AW:0] PIX_LIMIT  = (AW+1)'(HSIZE * VSIZE);
  localparam logic [7:0]  STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]    starve_cnt_reg, starve_cnt_next;
  logic          force_wr, grant_wr, grant_rd, drop_rd, wr_oob;
  logic          bram_en_reg, bram_we_reg, err_oob_reg;
  logic [AW-1:0] bram_addr_reg;
  logic [DW-1:0] bram_wdata_reg, rd_data_reg;
  logic          rd_s1_reg, rd_s2_reg, rd_valid_reg;
  logic          miss_s1_reg, miss_s2_reg, rd_miss_reg;
  logic [15:0]   miss_cnt_reg;

  assign force_wr = (starve_cnt_reg == STARVE_LIM);
  assign wr_ready = !rd_req || force_wr;

  // Every write transfer is a write grant; a read only wins when no write does.
  assign grant_wr = wr_valid && wr_ready;
  assign grant_rd = rd_req && !grant_wr;
  assign drop_rd  = rd_req && grant_wr;
  assign wr_oob   = ({1'b0, wr_addr} >= PIX_LIMIT);

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!wr_valid || grant_wr)
      starve_cnt_next = 8'd0;
    else if (starve_cnt_reg < STARVE_LIM)
      starve_cnt_next = starve_cnt_reg + 8'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      starve_cnt_reg <= 8'd0;
      bram_en_reg    <= 1'b0;
      bram_we_reg    <= 1'b0;
      bram_addr_reg  <= '0;
      bram_wdata_reg <= '0;
      err_oob_reg    <= 1'b0;
      rd_s1_reg      <= 1'b0;
      rd_s2_reg      <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_data_reg    <= '0;
      miss_s1_reg    <= 1'b0;
      miss_s2_reg    <= 1'b0;
      rd_miss_reg    <= 1'b0;
      miss_cnt_reg   <= 16'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      bram_en_reg    <= grant_rd || (grant_wr && !wr_oob);
      bram_we_reg    <= grant_wr && !wr_oob;
      err_oob_reg    <= grant_wr && wr_oob;
      if (grant_rd) begin
        bram_addr_reg <= rd_addr;
      end else if (grant_wr && !wr_oob) begin
        bram_addr_reg  <= wr_addr;
        bram_wdata_reg <= wr_data;
      end

      // Stage 1 drives the BRAM port, stage 2 waits out its read latency.
      rd_s1_reg    <= grant_rd;
      rd_s2_reg    <= rd_s1_reg;
      rd_valid_reg <= rd_s2_reg;
      if (rd_s2_reg)
        rd_data_reg <= bram_rdata;

      miss_s1_reg <= drop_rd;
      miss_s2_reg <= miss_s1_reg;
      rd_miss_reg <= miss_s2_reg;
      if (miss_s2_reg && miss_cnt_reg != 16'hFFFF)
        miss_cnt_reg <= miss_cnt_reg + 16'd1;
    end
  end

  assign bram_en    = bram_en_reg;
  assign bram_we    = bram_we_reg;
  assign bram_addr  = bram_addr_reg;
  assign bram_wdata = bram_wdata_reg;
  assign err_oob    = err_oob_reg;
  assign rd_valid   = rd_valid_reg;
  assign rd_data    = rd_data_reg;
  assign rd_miss    = rd_miss_reg;
  assign miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_fb_bram_arbiter.sv
// Bench for fb_bram_arbiter: directed and random traffic compared cycle by
// cycle against a transaction-level model of the arbitration rules.
module tb_fb_bram_arbiter;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam int HSIZE = 640;
  localparam int VSIZE = 480;
  localparam int STARVE_MAX = 8;
  localparam int PIX = HSIZE * VSIZE;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          rd_req, wr_valid;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, rd_miss, wr_ready, err_oob;
  logic [15:0]   miss_cnt;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata, bram_rdata;

  fb_bram_arbiter #(.HSIZE(HSIZE), .VSIZE(VSIZE), .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RESET(RESET),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_miss(rd_miss),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .err_oob(err_oob), .miss_cnt(miss_cnt),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata)
  );

  always #5 CLK = ~CLK;

  // Frame-buffer BRAM: unwritten words read back as their own address.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            wrote [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr]   <= bram_wdata;
        wrote[bram_addr] <= 1'b1;
      end else begin
        bram_rdata <= wrote[bram_addr] ? mem[bram_addr] : 16'(bram_addr);
      end
    end
  end

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic        rd;
    logic        miss;
    logic [15:0] data;
  } ev_t;

  logic [15:0]   ref_mem [int];
  int            m_starve;
  ev_t           s1, s2;
  logic          e_en, e_we, e_oob, e_valid, e_miss;
  logic [AW-1:0] e_addr;
  logic [15:0]   e_wdata, e_rdata;
  int            e_miss_cnt;

  function automatic logic [15:0] mem_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    s1 = '0;
    s2 = '0;
    e_en = 0; e_we = 0; e_oob = 0; e_valid = 0; e_miss = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    e_miss_cnt = 0;
  endtask

  task automatic check_outs();
    chk("bram_en", 32'(bram_en), 32'(e_en));
    chk("bram_we", 32'(bram_we), 32'(e_we));
    chk("bram_addr", 32'(bram_addr), 32'(e_addr));
    chk("bram_wdata", 32'(bram_wdata), 32'(e_wdata));
    chk("err_oob", 32'(err_oob), 32'(e_oob));
    chk("rd_valid", 32'(rd_valid), 32'(e_valid));
    chk("rd_data", 32'(rd_data), 32'(e_rdata));
    chk("rd_miss", 32'(rd_miss), 32'(e_miss));
    chk("miss_cnt", 32'(miss_cnt), 32'(e_miss_cnt));
  endtask

  // One clock of traffic: drive, check wr_ready, predict, clock, check outputs.
  task automatic step(input bit rq, input int ra, input bit wv, input int wa,
                      input logic [15:0] wd, output bit xfer);
    bit  force_w, rdy, gw, gr;
    ev_t nev;
    rd_req = rq; rd_addr = AW'(ra);
    wr_valid = wv; wr_addr = AW'(wa); wr_data = wd;
    #1;
    force_w = (m_starve == STARVE_MAX);
    rdy = !rq || force_w;
    chk("wr_ready", 32'(wr_ready), 32'(rdy));
    gw = wv && rdy;
    gr = rq && !gw;
    nev.rd = gr;
    nev.miss = rq && gw;
    nev.data = gr ? mem_rd(ra) : 16'h0;
    if (gw && wa < PIX) ref_mem[wa] = wd;
    if (!wv || gw) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;
    e_en = gr || (gw && wa < PIX);
    e_we = gw && wa < PIX;
    e_oob = gw && wa >= PIX;
    if (gr) e_addr = AW'(ra);
    else if (e_we) begin e_addr = AW'(wa); e_wdata = wd; end
    e_valid = s2.rd;
    e_miss = s2.miss;
    if (s2.rd) e_rdata = s2.data;
    if (s2.miss && e_miss_cnt < 65535) e_miss_cnt++;
    s2 = s1;
    s1 = nev;
    xfer = gw;
    $display("t=%0t rd_req=%0d rd_addr=%0d wr_valid=%0d wr_addr=%0d grant=%s", $time, rq, ra, wv, wa,
             gw ? (rq ? "wr_forced" : "wr") : (gr ? "rd" : "idle"));
    @(posedge CLK);
    #1;
    check_outs();
  endtask

  task automatic idle(input int n);
    bit x;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0, x);
  endtask

  initial begin
    bit x;
    int xfer_at;
    bit pend_v;
    int pend_a;
    logic [15:0] pend_d;

    RESET = 1'b1;
    rd_req = 0; rd_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0;
    model_reset();
    #23;
    check_outs();
    @(negedge CLK);
    RESET = 1'b0;

    // Full line of scanout reads.
    for (int i = 0; i < HSIZE; i++) step(1, i, 0, 0, 16'h0, x);
    idle(2);

    // Plain write, then read back.
    step(0, 0, 1, 100, 16'hF800, x);
    chk("wr100_xfer", 32'(x), 32'd1);
    step(1, 100, 0, 0, 16'h0, x);
    idle(2);
    chk("rd100_data", 32'(rd_data), 32'hF800);

    // Starvation under continuous reads: write forced on the 9th cycle.
    xfer_at = -1;
    for (int i = 0; i < STARVE_MAX + 1; i++) begin
      step(1, 300 + i, 1, 200, 16'h07E0, x);
      if (x && xfer_at < 0) xfer_at = i;
    end
    chk("starve_xfer_cycle", 32'(xfer_at), 32'(STARVE_MAX));
    step(1, 200, 0, 0, 16'h0, x);
    step(1, 201, 0, 0, 16'h0, x);
    idle(2);
    chk("starve_miss_cnt", 32'(miss_cnt), 32'd1);

    // Address boundary: last pixel accepted, first beyond flagged.
    step(0, 0, 1, PIX - 1, 16'hABCD, x);
    step(0, 0, 1, PIX, 16'h1234, x);
    chk("oob_xfer", 32'(x), 32'd1);
    idle(1);
    step(1, PIX - 1, 0, 0, 16'h0, x);
    idle(2);

    // Random mixed traffic on a small address window.
    pend_v = 0; pend_a = 0; pend_d = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!pend_v && $urandom_range(0, 99) < 60) begin
        pend_v = 1;
        pend_a = ($urandom_range(0, 19) == 0) ? PIX + int'($urandom_range(0, 100)) : int'($urandom_range(0, 63));
        pend_d = 16'($urandom);
      end
      step($urandom_range(0, 99) < 70, int'($urandom_range(0, 63)), pend_v, pend_a, pend_d, x);
      if (x) pend_v = 0;
    end
    idle(3);

    // Asynchronous reset between two granted reads.
    step(1, 10, 0, 0, 16'h0, x);
    step(1, 11, 0, 0, 16'h0, x);
    rd_req = 0;
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    check_outs();
    #2;
    RESET = 1'b0;
    idle(4);

    // Miss counter saturation under repeated forced writes.
    force dut.miss_cnt_reg = 16'hFFFD;
    #1;
    release dut.miss_cnt_reg;
    e_miss_cnt = 65533;
    chk("miss_cnt_preset", 32'(miss_cnt), 32'hFFFD);
    for (int i = 0; i < 5 * (STARVE_MAX + 1); i++)
      step(1, i, 1, 400, 16'h001F, x);
    step(1, 0, 0, 0, 16'h0, x);
    step(1, 1, 0, 0, 16'h0, x);
    chk("miss_cnt_sat", 32'(miss_cnt), 32'hFFFF);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
